// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory / output-register arbiter.
// Region codes come from address bits [15:12].
package mem_arb_pkg;

    localparam logic [3:0] REGION_MEM = 4'h0;
    localparam logic [3:0] REGION_OUT = 4'h1;

    // 0 = multicycle CPU, 1 = line-drawing engine
    typedef logic port_t;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_OUT,
        SRC_NONE
    } src_e;

    function automatic src_e decode_src(input logic [3:0] region);
        src_e src;
        case (region)
            REGION_MEM: src = SRC_MEM;
            REGION_OUT: src = SRC_OUT;
            default:    src = SRC_NONE;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin arbiter with a same-cycle grant.
// The last-grant pointer moves only when a grant is issued, which always means a transfer is accepted.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output port_t      last_o
);

    port_t last_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // On a tie, grant the port that was not granted most recently.
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (|gnt_o) begin
            last_q <= gnt_o[1];
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the 128x16 memory and the write-only output register between the CPU (port 0)
// and the line engine (port 1). Read data returns one cycle after acceptance.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_AW = 7
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic [1:0]        i_Req,
    input  logic [1:0]        i_We,
    input  logic [15:0]       i_Addr0,
    input  logic [15:0]       i_Addr1,
    input  logic [15:0]       i_Wdata0,
    input  logic [15:0]       i_Wdata1,
    output logic [1:0]        o_Gnt,
    output logic [1:0]        o_Rvalid,
    output logic [15:0]       o_Rdata,
    output logic [MEM_AW-1:0] o_Mem_Addr,
    output logic [15:0]       o_Mem_Data,
    output logic              o_Mem_Wren,
    input  logic [15:0]       i_Mem_Q,
    output logic [15:0]       o_Data
);

    logic [1:0]  gnt;
    logic        accept;
    port_t       sel;
    port_t       unused_last;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        we;
    src_e        src;
    logic        unused_addr;

    logic [15:0] data_q;
    logic [1:0]  rvalid_q;
    src_e        src_q;

    rr_arbiter2 u_arb (
        .clk_i  (i_Clock),
        .rst_i  (i_Reset),
        .req_i  (i_Req),
        .en_i   (~i_Reset),
        .gnt_o  (gnt),
        .last_o (unused_last)
    );

    assign o_Gnt  = gnt;
    assign accept = |gnt;
    // With no grant, sel is 0 so the memory bus idles on port 0's inputs.
    assign sel    = gnt[1];

    always_comb begin
        addr  = sel ? i_Addr1  : i_Addr0;
        wdata = sel ? i_Wdata1 : i_Wdata0;
        we    = sel ? i_We[1]  : i_We[0];
        src   = decode_src(addr[15:12]);
    end

    // Bits between the word index and the region field are ignored, so addresses alias.
    assign unused_addr = ^addr[11:MEM_AW];

    assign o_Mem_Addr = addr[MEM_AW-1:0];
    assign o_Mem_Data = wdata;
    assign o_Mem_Wren = accept & we & (src == SRC_MEM);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            data_q   <= 16'h0000;
            rvalid_q <= 2'b00;
            src_q    <= SRC_NONE;
        end else begin
            if (accept && we && (src == SRC_OUT)) begin
                data_q <= wdata;
            end
            rvalid_q <= (accept && !we) ? gnt : 2'b00;
            if (accept && !we) begin
                src_q <= src;
            end
        end
    end

    // A read never coincides with a write, so data_q here is still the value seen at the accept edge.
    always_comb begin
        case (src_q)
            SRC_MEM: o_Rdata = i_Mem_Q;
            SRC_OUT: o_Rdata = data_q;
            default: o_Rdata = 16'h0000;
        endcase
    end

    assign o_Rvalid = rvalid_q;
    assign o_Data   = data_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 128x16 on-chip memory and the 16-bit output register between two bus masters: port 0 is the multicycle processor and port 1 is the line-drawing engine. It performs round-robin arbitration with a same-cycle grant, decodes the address region, and returns read data one cycle after acceptance. It owns the write-only output register (region 1) that drives o_Data, and it sits between both masters and the memory instance.

## Interface
- Parameters
- MEM_AW, 7, memory word-address width; addresses the low MEM_AW bits of the 16-bit address.
- Ports
- i_Clock  in  1  system clock; all state updates on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Req[1:0]  in  2  per-port request.
- i_We[1:0]  in  2  per-port write enable; 0 = read.
- i_Addr0, i_Addr1  in  16 each  per-port address.
- i_Wdata0, i_Wdata1  in  16 each  per-port write data.
- o_Gnt[1:0]  out  2  per-port grant, combinational, one-hot or zero.
- o_Rvalid[1:0]  out  2  per-port read-data valid, registered.
- o_Rdata  out  16  read data, shared by both ports and qualified by o_Rvalid.
- o_Mem_Addr  out  MEM_AW  memory address.
- o_Mem_Data  out  16  memory write data.
- o_Mem_Wren  out  1  memory write enable.
- i_Mem_Q  in  16  memory read data, valid one cycle after the address edge.
- o_Data  out  16  output register (region 1).

## Operation
- **Region decode** uses Addr[15:12]:
  - 4'h0: memory.
  - 4'h1: output register.
  - Any other value: unmapped.
- **Handshake**
  - A master holds Req, We, Addr and Wdata stable until it samples Gnt high.
  - A transfer is accepted in any cycle where Req[p] & Gnt[p]. At most one transfer is accepted per cycle.
  - A master may issue back-to-back requests; a port can be granted in consecutive cycles when the other port is idle.
- **Arbitration**
  - If only one port requests, that port is granted.
  - If both ports request, the port not granted most recently is granted.
  - The last-grant pointer updates only on acceptance. Reset value of the pointer is 1, so port 0 wins the first tie.
- **Accepted write**
  - Region 0: o_Mem_Wren=1, o_Mem_Addr=Addr[MEM_AW-1:0], o_Mem_Data=Wdata.
  - Region 1: o_Data<=Wdata at the edge.
  - Unmapped: silently dropped.
  - No Rvalid is produced for any write.
- **Accepted read**
  - Region 0: o_Mem_Addr is driven. In the next cycle o_Rdata=i_Mem_Q.
  - Region 1: o_Rdata in the next cycle equals the o_Data value at the accept edge.
  - Unmapped: o_Rdata=16'h0000.
  - In every case o_Rvalid[p]=1 for exactly one cycle.
- **Idle memory outputs:** when no transfer is accepted, o_Mem_Wren=0. o_Mem_Addr and o_Mem_Data follow port 0 inputs (don't-care).
- **Tag registers:** registered read tags (port, source select) are held in a 1-entry return stage. Because the memory has 1-cycle latency, there is no return backpressure.

## Timing
- Grant latency is 0 cycles: a Req seen in cycle N can be granted in cycle N.
- Read latency is 1 cycle: a read accepted in cycle N has o_Rvalid high in cycle N+1 only.
- Write to region 1 accepted in cycle N: o_Data shows the new value from cycle N+1.
- Read-after-write to the same address on back-to-back accepts returns the new data. The memory is written at edge N and read at edge N+1.
- **Reset values:** o_Data=0, o_Rvalid=0, o_Rdata=0, pointer=1.
- **While i_Reset is high:** o_Gnt=0 and o_Mem_Wren=0, independent of requests.
- **Reset asserted in cycle N+1 after a read accept in N:** the cycle-N+1 Rvalid still shows, because it is registered. No Rvalid appears after that, and no pending state survives reset.
- **Sustained contention:** grants alternate 0,1,0,1. Neither port waits more than 1 cycle.

## Structure
- Package mem_arb_pkg holds:
  - REGION_MEM=4'h0 and REGION_OUT=4'h1.
  - typedef port_t (logic, 0 = CPU, 1 = line engine).
  - typedef src_e {SRC_MEM, SRC_OUT, SRC_NONE} for the return mux.
- One sub-module, rr_arbiter2:
  - Inputs: req[1:0] and an accept enable.
  - Outputs: one-hot gnt and the last-grant pointer.
  - Synchronous active-high reset.
- Decode, memory muxing, the output register and the return stage live in mem_arbiter.

## Test plan
- Reset then single read: reset 3 cycles, then port 0 reads 0x0005 with mem[5]=16'hBEEF. Required: Gnt[0] in the same cycle, Rvalid[0] next cycle, o_Rdata=16'hBEEF, Rvalid[1]=0 throughout.
- Contention: both ports hold write requests for 4 cycles. Required: grants 0,1,0,1 and o_Mem_Wren=1 in all 4 cycles with the correct address/data each cycle.
- Output register: port 1 writes 16'h1234 to 0x1000, then reads 0x1000 back-to-back. Required: o_Data=16'h1234 from the next cycle, and the read returns 16'h1234.
- Unmapped accesses: write 16'hFFFF to 0x8003, then read 0x8003. Required: o_Mem_Wren=0, o_Data unchanged, read returns 16'h0000 with Rvalid.
- Aliasing and RAW: port 0 writes 16'hA5A5 to 0x007F, then port 1 reads 0x007F next cycle. Required: port 1 sees 16'hA5A5. A write to 0x0080 hits word 0x00 (MEM_AW=7).
- Mid-operation reset: read accepted in cycle N, reset raised in N+1 with both Req high. Required: Rvalid pulse in N+1 only, Gnt=0 and o_Mem_Wren=0 during reset, o_Data=0, and port 0 wins the first tie after release.
